// File: rtl/fu_seq_pkg.sv
// fu_seq_pkg: shared types and constants for the fu_sequencer slice.
//   state_e    - sequencer FSM states
//   COND_*     - condition-code encodings (used only when FU_SEQ_COND_EN is defined)
//   OP_*       - FU opcode group on opcode[3:2]; opcode[0] selects subtract in OP_ADD
//   cond_pass  - evaluates a condition code against the low two flag bits
package fu_seq_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StExec = 2'd1,
      StWb   = 2'd2
   } state_e;

   localparam logic [1:0] COND_ALWAYS = 2'b00;
   localparam logic [1:0] COND_F0     = 2'b01;
   localparam logic [1:0] COND_NF0    = 2'b10;
   localparam logic [1:0] COND_F1     = 2'b11;

   localparam logic [1:0] OP_LOGIC = 2'b00;
   localparam logic [1:0] OP_ADD   = 2'b01;
   localparam logic [1:0] OP_MUL   = 2'b10;
   localparam logic [1:0] OP_SHIFT = 2'b11;

   function automatic logic cond_pass(input logic [1:0] cond, input logic [1:0] flg);
      logic pass;
      pass = 1'b1;
      case (cond)
         COND_ALWAYS: pass = 1'b1;
         COND_F0:     pass = flg[0];
         COND_NF0:    pass = ~flg[0];
         COND_F1:     pass = flg[1];
         default:     pass = 1'b1;
      endcase
      return pass;
   endfunction

endpackage

// File: rtl/fu_regfile.sv
// fu_regfile: NREGS x WIDTH register file for fu_sequencer.
// Ports:
//   clk, rst           - clock, asynchronous active-high reset (clears all entries)
//   i_we/i_waddr/i_wdata - single synchronous write port; writes to r0 are dropped
//   i_raddr_a/o_rdata_a  - asynchronous read port (rs1)
//   i_raddr_b/o_rdata_b  - asynchronous read port (rs2)
//   i_raddr_d/o_rdata_d  - asynchronous read port (debug)
// r0 always reads as zero.
module fu_regfile #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned NREGS = 8,
   localparam int unsigned AW = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr_a,
   output logic [WIDTH-1:0] o_rdata_a,
   input  logic [AW-1:0]    i_raddr_b,
   output logic [WIDTH-1:0] o_rdata_b,
   input  logic [AW-1:0]    i_raddr_d,
   output logic [WIDTH-1:0] o_rdata_d
);

   logic [WIDTH-1:0] r_mem [NREGS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we && (i_waddr != '0)) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_mem[i_raddr_a];
   assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_mem[i_raddr_b];
   assign o_rdata_d = (i_raddr_d == '0) ? '0 : r_mem[i_raddr_d];

endmodule

// File: rtl/fu_sequencer.sv
// fu_sequencer: issue-side controller that turns the combinational FU into a
// registered, handshaked execution stage (IDLE -> EXEC -> WB, one op per 3 cycles).
// Ports:
//   clk, rst                       - clock, asynchronous active-high reset
//   instr_valid/instr_ready        - instruction handshake (ready only in IDLE, not while loading)
//   instr_op/rd/rs1/rs2/cond       - instruction fields
//   ld_en/ld_addr/ld_data          - register preload, honoured only in IDLE
//   dbg_addr/dbg_data              - combinational regfile peek
//   fu_a/fu_b/fu_opcode            - registered FU inputs
//   fu_y/fu_status                 - FU outputs, captured at the end of EXEC
//   done_valid/rd/data/skip        - completion report during WB
//   flags                          - last latched fu_status
// Optional feature: define FU_SEQ_COND_EN to enable conditional execution via instr_cond.
module fu_sequencer
   import fu_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned NREGS = 8,
   localparam int unsigned AW = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [3:0]       instr_op,
   input  logic [AW-1:0]    instr_rd,
   input  logic [AW-1:0]    instr_rs1,
   input  logic [AW-1:0]    instr_rs2,
   input  logic [1:0]       instr_cond,
   input  logic             ld_en,
   input  logic [AW-1:0]    ld_addr,
   input  logic [WIDTH-1:0] ld_data,
   input  logic [AW-1:0]    dbg_addr,
   output logic [WIDTH-1:0] dbg_data,
   output logic [WIDTH-1:0] fu_a,
   output logic [WIDTH-1:0] fu_b,
   output logic [3:0]       fu_opcode,
   input  logic [WIDTH-1:0] fu_y,
   input  logic [3:0]       fu_status,
   output logic             done_valid,
   output logic [AW-1:0]    done_rd,
   output logic [WIDTH-1:0] done_data,
   output logic             done_skip,
   output logic [3:0]       flags
);

   state_e           r_state, w_state_next;
   logic [WIDTH-1:0] r_fu_a, r_fu_b, r_result;
   logic [3:0]       r_fu_op, r_flags;
   logic [AW-1:0]    r_rd;
   logic             r_skip;
   logic             w_ready, w_accept, w_skip_next;
   logic             w_we;
   logic [AW-1:0]    w_waddr;
   logic [WIDTH-1:0] w_wdata, w_rs1_data, w_rs2_data;

`ifdef FU_SEQ_COND_EN
   assign w_skip_next = ~cond_pass(instr_cond, r_flags[1:0]);
`else
   logic w_unused_cond;
   assign w_unused_cond = ^instr_cond;
   assign w_skip_next   = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_ready      = 1'b0;
      w_accept     = 1'b0;
      w_we         = 1'b0;
      w_waddr      = ld_addr;
      w_wdata      = ld_data;
      unique case (r_state)
         StIdle: begin
            w_ready  = ~ld_en;
            w_accept = instr_valid & ~ld_en;
            w_we     = ld_en;
            if (w_accept) w_state_next = StExec;
         end
         StExec: w_state_next = StWb;
         StWb: begin
            // Suppressed ops still report completion but leave the regfile alone.
            w_we         = ~r_skip;
            w_waddr      = r_rd;
            w_wdata      = r_result;
            w_state_next = StIdle;
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fu_a   <= '0;
         r_fu_b   <= '0;
         r_fu_op  <= '0;
         r_rd     <= '0;
         r_skip   <= 1'b0;
         r_result <= '0;
         r_flags  <= '0;
      end else begin
         if (w_accept) begin
            r_fu_a  <= w_rs1_data;
            r_fu_b  <= w_rs2_data;
            r_fu_op <= instr_op;
            r_rd    <= instr_rd;
            r_skip  <= w_skip_next;
         end
         if (r_state == StExec) begin
            r_result <= fu_y;
            if (!r_skip) r_flags <= fu_status;
         end
      end
   end

   fu_regfile #(
      .WIDTH(WIDTH),
      .NREGS(NREGS)
   ) u_regfile (
      .clk       (clk),
      .rst       (rst),
      .i_we      (w_we),
      .i_waddr   (w_waddr),
      .i_wdata   (w_wdata),
      .i_raddr_a (instr_rs1),
      .o_rdata_a (w_rs1_data),
      .i_raddr_b (instr_rs2),
      .o_rdata_b (w_rs2_data),
      .i_raddr_d (dbg_addr),
      .o_rdata_d (dbg_data)
   );

   assign instr_ready = w_ready;
   assign fu_a        = r_fu_a;
   assign fu_b        = r_fu_b;
   assign fu_opcode   = r_fu_op;
   assign done_valid  = (r_state == StWb);
   assign done_rd     = r_rd;
   assign done_data   = r_result;
   assign done_skip   = (r_state == StWb) & r_skip;
   assign flags       = r_flags;

endmodule

// File: doc/fu_sequencer.md
# fu_sequencer

Issue-side controller for the combinational FunctionalUnit. It accepts one instruction at a time over a valid/ready handshake and reads two operands from an internal register file. It drives the FU's a/b/opcode inputs, captures y and status one cycle later, and writes the result back. It sits between instruction fetch/decode and the FU in the datapath, making the FU a registered, handshaked execution stage.

## Interface
- WIDTH, 16, datapath width; must match the FU width.
- NREGS, 8, register count (power of 2); AW = log2(NREGS).
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  sequencer can accept
- instr_op  in  4  FU opcode, passed through unchanged
- instr_rd, instr_rs1, instr_rs2  in  AW  destination and source registers
- instr_cond  in  2  condition code; ignored unless the macro is defined
- ld_en, ld_addr[AW], ld_data[WIDTH]  in  register preload port
- dbg_addr  in  AW  debug read address
- dbg_data  out  WIDTH  combinational read of regfile[dbg_addr]
- fu_a, fu_b  out  WIDTH  FU operands (registered)
- fu_opcode  out  4  FU opcode (registered)
- fu_y  in  WIDTH  FU result
- fu_status  in  4  FU status
- done_valid  out  1  one-cycle completion pulse
- done_rd  out  AW  destination register of the completed op
- done_data  out  WIDTH  result of the completed op
- done_skip  out  1  op was condition-suppressed; tied 0 without the macro
- flags  out  4  last latched fu_status

## Operation
- FSM states: IDLE, EXEC, WB.
  - IDLE → EXEC on instr_valid & instr_ready.
  - EXEC → WB unconditionally.
  - WB → IDLE unconditionally.
- instr_ready = (state==IDLE) & ~ld_en.
- Load port:
  - A load is honoured only in IDLE. It writes regfile[ld_addr] <= ld_data at the clock edge.
  - In other states ld_en is ignored.
  - Load has priority over instruction acceptance.
- Accept edge: fu_a <= R[rs1], fu_b <= R[rs2], fu_opcode <= instr_op. rd and cond are latched.
- EXEC end edge:
  - result register <= fu_y.
  - flags <= fu_status.
- WB: done_valid=1, done_rd and done_data show the latched values.
  - At the WB end edge, regfile[rd] <= result.
- r0 is hardwired to zero:
  - Writes to r0 from either the load or writeback path are discarded.
  - The done_* outputs still report the computed data.
- fu_a, fu_b and fu_opcode hold their last values outside EXEC.
- No hazards exist, because operation is fully serialised. An op whose rs equals the previous op's rd reads the written-back value.

## Timing
- Accept at edge E0. FU inputs are valid after E0. done_valid is high for the cycle between E1 and E2. The regfile update is visible on dbg_data after E2.
- Throughput: one op per 3 cycles.
- Reset values:
  - state IDLE.
  - All registers 0.
  - fu_a, fu_b, fu_opcode, flags, done_rd, done_data: 0.
  - done_valid and done_skip: 0.
  - instr_ready: 1, or 0 while ld_en=1.
- Reset mid-operation (EXEC or WB):
  - The op is aborted immediately.
  - No writeback occurs and no done pulse is produced.
  - Register contents are cleared by the reset.
- If instr_valid is held high, the next op is accepted on the first IDLE edge after WB.

## Configuration
- FU_SEQ_COND_EN defined: instr_cond is evaluated against flags at the accept edge.
  - Condition codes: 00 always; 01 if flags[0]; 10 if ~flags[0]; 11 if flags[1].
  - When the condition is false, the op still passes through EXEC and WB with done_valid=1 and done_skip=1.
  - A suppressed op updates neither the regfile nor flags.
- Macro undefined: every op executes, instr_cond is ignored, and done_skip=0.

## Structure
- Package fu_seq_pkg holds:
  - the state enum;
  - condition encodings (COND_ALWAYS, COND_F0, COND_NF0, COND_F1);
  - FU opcode group constants: OP_LOGIC=2'b00, OP_ADD=2'b01, OP_MUL=2'b10, OP_SHIFT=2'b11 on opcode[3:2]; opcode[0] selects subtract in the ADD group.
- One sub-module, fu_regfile:
  - NREGS×WIDTH;
  - three asynchronous read ports (rs1, rs2, dbg);
  - one synchronous write port, shared by load and writeback;
  - r0 reads as zero;
  - asynchronous reset to zero.

## Test plan
The bench connects the FunctionalUnit with WIDTH=16.
- Reset: assert rst, then release → instr_ready=1, dbg_data=0 for all addresses, flags=0, done_valid=0.
- ADD: load r1=0x0003, r2=0x0005; issue op=4'b0100, rd=3, rs1=1, rs2=2 → done_valid exactly one cycle, after E1; done_data=0x0008; dbg r3=0x0008 after E2.
- SUB and r0: op=4'b0101 with rs1=rs2=1 and rd=0 → done_data=0x0000; flags equal fu_status sampled in EXEC; r0 still reads 0.
- Back-to-back:
  - Hold instr_valid with op A (r3=r1+r2) then op B (r4 = r3 + r1, ADD).
  - Expected: instr_ready low in EXEC and WB; accepts 3 cycles apart; r4=0x000B.
- Reset mid-op: assert rst one cycle after acceptance → no done_valid pulse, state IDLE, registers cleared.
- FU_SEQ_COND_EN: flags[0]=0, issue cond=01 with rd=5 → done_valid=1, done_skip=1, r5 unchanged, flags unchanged. cond=10 → executes with done_skip=0.
